// File: rtl/bpu_pkg.sv
// Shared branch-prediction definitions: branch-type encodings, flush FSM states
// and the replacement LFSR constants used by the BTB.
package bpu_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JMP  = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  localparam logic [0:0] FSM_IDLE  = 1'b0;
  localparam logic [0:0] FSM_FLUSH = 1'b1;

  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [15:0] LFSR_TAP  = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAP : 16'h0000);
  endfunction

endpackage

// File: rtl/bpu_btb_repl.sv
// BTB victim-way selection. BTB_LRU_EN selects per-set true-LRU age counters;
// otherwise a 16-bit Galois LFSR picks the way on allocation into a full set.
module bpu_btb_repl
  import bpu_pkg::*;
#(
  parameter int unsigned NUM_SETS_W = 4,
  parameter int unsigned NUM_WAYS_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  lk_touch_i,
  input  logic [NUM_SETS_W-1:0] lk_set_i,
  input  logic [NUM_WAYS_W-1:0] lk_way_i,
  input  logic                  up_touch_i,
  input  logic [NUM_SETS_W-1:0] up_set_i,
  input  logic [NUM_WAYS_W-1:0] up_way_i,
  input  logic                  alloc_full_i,
  input  logic [NUM_SETS_W-1:0] vict_set_i,
  output logic [NUM_WAYS_W-1:0] vict_way_o
);

`ifdef BTB_LRU_EN
  localparam int unsigned SETS = 1 << NUM_SETS_W;
  localparam int unsigned WAYS = 1 << NUM_WAYS_W;

  typedef logic [WAYS-1:0][NUM_WAYS_W-1:0] age_row_t;

  age_row_t age_q [SETS];
  age_row_t age_d [SETS];
  logic     unused_ok;

  // Ages form a permutation of 0..WAYS-1; touching a way makes it 0 and ages
  // every younger way by one, so the oldest way always has age WAYS-1.
  function automatic age_row_t touch(input age_row_t row, input logic [NUM_WAYS_W-1:0] way);
    age_row_t                res;
    logic [NUM_WAYS_W-1:0]   ref_age;
    ref_age = row[way];
    res     = row;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (row[w] < ref_age) res[w] = row[w] + 1'b1;
    end
    res[way] = '0;
    return res;
  endfunction

  always_comb begin
    age_d = age_q;
    if (lk_touch_i && !(up_touch_i && (up_set_i == lk_set_i)))
      age_d[lk_set_i] = touch(age_q[lk_set_i], lk_way_i);
    if (up_touch_i)
      age_d[up_set_i] = touch(age_q[up_set_i], up_way_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          age_q[s][w] <= NUM_WAYS_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

  always_comb begin
    vict_way_o = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (age_q[vict_set_i][w] == '1) vict_way_o = NUM_WAYS_W'(w);
    end
  end

  assign unused_ok = alloc_full_i;
`else
  logic [15:0] lfsr_q;
  logic        unused_ok;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)           lfsr_q <= LFSR_SEED;
    else if (alloc_full_i) lfsr_q <= lfsr_step(lfsr_q);
  end

  assign vict_way_o = lfsr_q[NUM_WAYS_W-1:0];
  assign unused_ok  = ^{lk_touch_i, lk_set_i, lk_way_i, up_touch_i, up_set_i, up_way_i, vict_set_i};
`endif

endmodule

// File: rtl/bpu_btb_sa.sv
// Set-associative branch target buffer with 1-cycle registered lookup, training
// updates and a one-set-per-cycle flush. Define BTB_LRU_EN for LRU replacement.
module bpu_btb_sa
  import bpu_pkg::*;
#(
  parameter int unsigned NUM_SETS      = 16,
  parameter int unsigned NUM_SETS_W    = 4,
  parameter int unsigned NUM_WAYS      = 4,
  parameter int unsigned NUM_WAYS_W    = 2,
  parameter int unsigned FETCH_SLOTS_W = 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     lookup_valid_i,
  input  logic [31:0]              lookup_pc_i,
  output logic                     lookup_hit_o,
  output logic [FETCH_SLOTS_W-1:0] lookup_slot_o,
  output logic [31:0]              lookup_target_o,
  output logic [1:0]               lookup_type_o,
  input  logic                     update_valid_i,
  input  logic [31:0]              update_pc_i,
  input  logic [31:0]              update_target_i,
  input  logic [1:0]               update_type_i,
  input  logic                     update_taken_i,
  input  logic                     flush_i,
  output logic                     busy_o
);

  localparam int unsigned BOFF  = 2 + FETCH_SLOTS_W;
  localparam int unsigned SHI   = BOFF + NUM_SETS_W - 1;
  localparam int unsigned TAG_W = 32 - BOFF - NUM_SETS_W;

  logic [NUM_WAYS-1:0]      valid_q [NUM_SETS];
  logic [TAG_W-1:0]         tag_q   [NUM_SETS][NUM_WAYS];
  logic [FETCH_SLOTS_W-1:0] eslot_q [NUM_SETS][NUM_WAYS];
  logic [31:0]              tgt_q   [NUM_SETS][NUM_WAYS];
  br_type_e                 type_q  [NUM_SETS][NUM_WAYS];

  logic [0:0]            state_q, state_d;
  logic [NUM_SETS_W-1:0] fset_q, fset_d;

  logic                     hit_q;
  logic [FETCH_SLOTS_W-1:0] oslot_q;
  logic [31:0]              otgt_q;
  logic [1:0]               otype_q;

  logic [NUM_SETS_W-1:0]    lk_set, up_set;
  logic [TAG_W-1:0]         lk_tag, up_tag;
  logic [FETCH_SLOTS_W-1:0] lk_slot, up_slot, lk_best;
  logic                     lk_found, lk_ok;
  logic [NUM_WAYS_W-1:0]    lk_way;
  logic                     up_hit, up_inv, up_en, wr_hit, alloc, up_touch;
  logic [NUM_WAYS_W-1:0]    up_hit_way, up_inv_way, vict_way, alloc_way, wr_way;
  logic                     unused_ok;

  assign lk_set  = lookup_pc_i[SHI:BOFF];
  assign lk_tag  = lookup_pc_i[31:SHI+1];
  assign lk_slot = lookup_pc_i[BOFF-1:2];
  assign up_set  = update_pc_i[SHI:BOFF];
  assign up_tag  = update_pc_i[31:SHI+1];
  assign up_slot = update_pc_i[BOFF-1:2];
  assign unused_ok = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  // Lowest qualifying slot wins; strict compare keeps the lowest way on ties.
  always_comb begin
    lk_found = 1'b0;
    lk_way   = '0;
    lk_best  = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag) && (eslot_q[lk_set][w] >= lk_slot)
          && (!lk_found || (eslot_q[lk_set][w] < lk_best))) begin
        lk_found = 1'b1;
        lk_way   = NUM_WAYS_W'(w);
        lk_best  = eslot_q[lk_set][w];
      end
    end
  end

  assign lk_ok = lookup_valid_i && lk_found && (state_q == FSM_IDLE) && !flush_i;

  always_comb begin
    up_hit     = 1'b0;
    up_hit_way = '0;
    up_inv     = 1'b0;
    up_inv_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!up_hit && valid_q[up_set][w] && (tag_q[up_set][w] == up_tag) && (eslot_q[up_set][w] == up_slot)) begin
        up_hit     = 1'b1;
        up_hit_way = NUM_WAYS_W'(w);
      end
      if (!up_inv && !valid_q[up_set][w]) begin
        up_inv     = 1'b1;
        up_inv_way = NUM_WAYS_W'(w);
      end
    end
  end

  assign up_en     = update_valid_i && (state_q == FSM_IDLE) && !flush_i;
  assign wr_hit    = up_en && up_hit && update_taken_i;
  assign alloc     = up_en && !up_hit && update_taken_i;
  assign alloc_way = up_inv ? up_inv_way : vict_way;
  assign wr_way    = up_hit ? up_hit_way : alloc_way;
  assign up_touch  = up_en && (up_hit || update_taken_i);

  bpu_btb_repl #(
    .NUM_SETS_W (NUM_SETS_W),
    .NUM_WAYS_W (NUM_WAYS_W)
  ) u_repl (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .lk_touch_i   (lk_ok),
    .lk_set_i     (lk_set),
    .lk_way_i     (lk_way),
    .up_touch_i   (up_touch),
    .up_set_i     (up_set),
    .up_way_i     (wr_way),
    .alloc_full_i (alloc && !up_inv),
    .vict_set_i   (up_set),
    .vict_way_o   (vict_way)
  );

  always_ff @(posedge clk_i) begin
    if (wr_hit || alloc) begin
      tgt_q[up_set][wr_way]  <= update_target_i;
      type_q[up_set][wr_way] <= br_type_e'(update_type_i);
    end
    if (alloc) begin
      tag_q[up_set][wr_way]   <= up_tag;
      eslot_q[up_set][wr_way] <= up_slot;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (state_q == FSM_FLUSH) begin
      valid_q[fset_q] <= '0;
    end else if (alloc) begin
      valid_q[up_set][wr_way] <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    fset_d  = fset_q;
    case (state_q)
      FSM_IDLE: begin
        if (flush_i) begin
          state_d = FSM_FLUSH;
          fset_d  = '0;
        end
      end
      default: begin
        fset_d = fset_q + 1'b1;
        if (fset_q == NUM_SETS_W'(NUM_SETS - 1)) state_d = FSM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= FSM_IDLE;
      fset_q  <= '0;
      hit_q   <= 1'b0;
      oslot_q <= '0;
      otgt_q  <= '0;
      otype_q <= '0;
    end else begin
      state_q <= state_d;
      fset_q  <= fset_d;
      hit_q   <= lk_ok;
      oslot_q <= lk_ok ? lk_best : '0;
      otgt_q  <= lk_ok ? tgt_q[lk_set][lk_way] : '0;
      otype_q <= lk_ok ? 2'(type_q[lk_set][lk_way]) : 2'b00;
    end
  end

  assign lookup_hit_o    = hit_q;
  assign lookup_slot_o   = oslot_q;
  assign lookup_target_o = otgt_q;
  assign lookup_type_o   = otype_q;
  assign busy_o          = (state_q == FSM_FLUSH);

endmodule

// File: tb/tb_bpu_btb_sa.sv
// Directed self-checking bench for bpu_btb_sa (8-byte fetch blocks, 16 sets x 4 ways).
module tb_bpu_btb_sa;
  import bpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        lookup_valid_i = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        lookup_hit_o;
  logic [0:0]  lookup_slot_o;
  logic [31:0] lookup_target_o;
  logic [1:0]  lookup_type_o;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic [31:0] update_target_i = '0;
  logic [1:0]  update_type_i = '0;
  logic        update_taken_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  bpu_btb_sa #(
    .NUM_SETS(16), .NUM_SETS_W(4), .NUM_WAYS(4), .NUM_WAYS_W(2), .FETCH_SLOTS_W(1)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .lookup_hit_o(lookup_hit_o), .lookup_slot_o(lookup_slot_o),
    .lookup_target_o(lookup_target_o), .lookup_type_o(lookup_type_o),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_target_i(update_target_i), .update_type_i(update_type_i),
    .update_taken_i(update_taken_i),
    .flush_i(flush_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, output logic hit, output logic [0:0] slot,
                        output logic [31:0] tgt, output logic [1:0] ty);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = pc;
    step();
    hit  = lookup_hit_o;
    slot = lookup_slot_o;
    tgt  = lookup_target_o;
    ty   = lookup_type_o;
    lookup_valid_i = 1'b0;
    lookup_pc_i    = '0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ty,
                        input logic taken);
    update_valid_i  = 1'b1;
    update_pc_i     = pc;
    update_target_i = tgt;
    update_type_i   = ty;
    update_taken_i  = taken;
    step();
    update_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (lookup_hit_o !== 1'b0) begin errors++; $display("FAIL rst_hit got=%0b exp=0", lookup_hit_o); end
    checks++; if (lookup_slot_o !== 1'b0) begin errors++; $display("FAIL rst_slot got=%0b exp=0", lookup_slot_o); end
    checks++; if (lookup_target_o !== 32'h0) begin errors++; $display("FAIL rst_target got=%h exp=0", lookup_target_o); end
    checks++; if (lookup_type_o !== 2'd0) begin errors++; $display("FAIL rst_type got=%0d exp=0", lookup_type_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
    rstn_i = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic h; logic [0:0] s; logic [31:0] t; logic [1:0] y;
    lookup(32'h0000_1000, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL cold_hit got=%0b exp=0", h); end
    update(32'h0000_1004, 32'h0000_2000, BR_JMP, 1'b1);
    lookup(32'h0000_1000, h, s, t, y);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL basic_hit got=%0b exp=1", h); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL basic_slot got=%0d exp=1", s); end
    checks++; if (t !== 32'h0000_2000) begin errors++; $display("FAIL basic_target got=%h exp=00002000", t); end
    checks++; if (y !== 2'd1) begin errors++; $display("FAIL basic_type got=%0d exp=1", y); end
  endtask

  task automatic test_slot_priority();
    logic h; logic [0:0] s; logic [31:0] t; logic [1:0] y;
    update(32'h0000_1000, 32'h0000_3000, BR_COND, 1'b1);
    lookup(32'h0000_1000, h, s, t, y);
    checks++; if (h !== 1'b1 || s !== 1'b0) begin errors++; $display("FAIL prio_slot0 got hit=%0b slot=%0d exp hit=1 slot=0", h, s); end
    checks++; if (t !== 32'h0000_3000 || y !== 2'd0) begin errors++; $display("FAIL prio_slot0_data got=%h/%0d exp=00003000/0", t, y); end
    lookup(32'h0000_1004, h, s, t, y);
    checks++; if (h !== 1'b1 || s !== 1'b1) begin errors++; $display("FAIL prio_slot1 got hit=%0b slot=%0d exp hit=1 slot=1", h, s); end
    checks++; if (t !== 32'h0000_2000) begin errors++; $display("FAIL prio_slot1_target got=%h exp=00002000", t); end
  endtask

  task automatic test_update_hit();
    logic h; logic [0:0] s; logic [31:0] t; logic [1:0] y;
    update(32'h0000_1004, 32'h0000_2400, BR_CALL, 1'b1);
    lookup(32'h0000_1004, h, s, t, y);
    checks++; if (t !== 32'h0000_2400 || y !== 2'd2) begin errors++; $display("FAIL taken_hit got=%h/%0d exp=00002400/2", t, y); end
    update(32'h0000_1004, 32'h0000_9990, BR_RET, 1'b0);
    lookup(32'h0000_1004, h, s, t, y);
    checks++; if (h !== 1'b1 || t !== 32'h0000_2400 || y !== 2'd2) begin errors++; $display("FAIL nt_hit got=%0b/%h/%0d exp=1/00002400/2", h, t, y); end
  endtask

  task automatic test_back_to_back();
    logic h; logic [0:0] s; logic [31:0] t; logic [1:0] y;
    lookup_valid_i = 1'b1; lookup_pc_i = 32'h0000_2000;
    update_valid_i = 1'b1; update_pc_i = 32'h0000_2000; update_target_i = 32'h0000_5000;
    update_type_i = BR_JMP; update_taken_i = 1'b1;
    step();
    update_valid_i = 1'b0; lookup_valid_i = 1'b0;
    checks++; if (lookup_hit_o !== 1'b0) begin errors++; $display("FAIL rbw_same_cycle got=%0b exp=0", lookup_hit_o); end
    lookup(32'h0000_2000, h, s, t, y);
    checks++; if (h !== 1'b1 || t !== 32'h0000_5000) begin errors++; $display("FAIL rbw_after got=%0b/%h exp=1/00005000", h, t); end
    step();
    checks++; if (lookup_hit_o !== 1'b0 || lookup_target_o !== 32'h0) begin errors++; $display("FAIL idle_out got=%0b/%h exp=0/00000000", lookup_hit_o, lookup_target_o); end
  endtask

  task automatic test_flush();
    logic h; logic [0:0] s; logic [31:0] t; logic [1:0] y;
    int n; int bad;
    flush_i = 1'b1;
    update_valid_i = 1'b1; update_pc_i = 32'h0000_1100; update_target_i = 32'h0000_6000;
    update_type_i = BR_JMP; update_taken_i = 1'b1;
    lookup_valid_i = 1'b1; lookup_pc_i = 32'h0000_1000;
    step();
    flush_i = 1'b0; update_valid_i = 1'b0;
    n = 0; bad = 0;
    while (busy_o === 1'b1 && n < 40) begin
      n++;
      if (lookup_hit_o !== 1'b0) bad++;
      if (n == 5) flush_i = 1'b1;
      step();
      flush_i = 1'b0;
    end
    if (lookup_hit_o !== 1'b0) bad++;
    lookup_valid_i = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL flush_busy_len got=%0d exp=16", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_hits_during got=%0d exp=0", bad); end
    lookup(32'h0000_1000, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL flush_miss_1000 got=%0b exp=0", h); end
    lookup(32'h0000_1004, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL flush_miss_1004 got=%0b exp=0", h); end
    lookup(32'h0000_2000, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL flush_miss_2000 got=%0b exp=0", h); end
    lookup(32'h0000_1100, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL flush_drop_upd got=%0b exp=0", h); end
  endtask

  // Set 0, slot 0, tags 0x20+k. Without LRU the LFSR seed selects way 1 for the
  // first full-set allocation; with LRU the first-filled way is the oldest.
  task automatic test_eviction();
    logic h; logic [0:0] s; logic [31:0] t; logic [1:0] y;
    int ev;
`ifdef BTB_LRU_EN
    ev = 0;
`else
    ev = 1;
`endif
    for (int k = 0; k < 4; k++) update(32'h0000_1000 + k * 32'h80, 32'h0000_4000 + k * 32'h100, BR_JMP, 1'b1);
    update(32'h0000_1300, 32'h0000_4600, BR_JMP, 1'b0);
    update(32'h0000_1200, 32'h0000_4400, BR_JMP, 1'b1);
    lookup(32'h0000_1300, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL nt_miss_alloc got=%0b exp=0", h); end
    for (int k = 0; k < 5; k++) begin
      lookup(32'h0000_1000 + k * 32'h80, h, s, t, y);
      if (k == ev) begin
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL evict_victim k=%0d got=%0b exp=0", k, h); end
      end else begin
        checks++; if (h !== 1'b1 || t !== 32'h0000_4000 + k * 32'h100) begin
          errors++; $display("FAIL evict_keep k=%0d got=%0b/%h exp=1/%h", k, h, t, 32'h0000_4000 + k * 32'h100);
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    logic h; logic [0:0] s; logic [31:0] t; logic [1:0] y;
    update(32'h0000_1050, 32'h0000_7000, BR_JMP, 1'b1);
    lookup(32'h0000_1050, h, s, t, y);
    checks++; if (h !== 1'b1 || t !== 32'h0000_7000) begin errors++; $display("FAIL set10_hit got=%0b/%h exp=1/00007000", h, t); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (4) step();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_cycle5 got=%0b exp=1", busy_o); end
    rstn_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_abort_busy got=%0b exp=0", busy_o); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%0b exp=0", busy_o); end
    lookup(32'h0000_1050, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL post_rst_set10 got=%0b exp=0", h); end
    lookup(32'h0000_1200, h, s, t, y);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL post_rst_set0 got=%0b exp=0", h); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slot_priority();
    test_update_hit();
    test_back_to_back();
    test_flush();
    test_eviction();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
